// File: rtl/mod_arith_rsd2bin.sv
// Redundant-signed-digit to binary converter: res = (ap - an) mod p, computed
// one 32-bit word per cycle, with a subtract pass and an optional add-back pass.
module mod_arith_rsd2bin (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clr,
    input  logic [255:0] ap,
    input  logic [255:0] an,
    input  logic [255:0] mod_p,
    output logic [255:0] res,
    output logic         flg_neg,
    output logic         busy,
    output logic         done
);

    localparam int unsigned W      = 256;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       ap_r, an_r, p_r, work;
    logic [IDX_W-1:0]   idx;
    logic               cy;
    logic               neg;
    logic               load_c, step_c, fin_c, last_c;
    logic [7:0]         off_c;
    logic [WORD_W-1:0]  opa_c, opb_c;
    logic [WORD_W:0]    sum_c;

    // Word-serial adder/subtractor shared by SUB and FIX
    always_comb begin
        off_c = {idx, 5'b0};
        opa_c = (state_q == SUB) ? ap_r[off_c +: WORD_W] : work[off_c +: WORD_W];
        opb_c = (state_q == SUB) ? an_r[off_c +: WORD_W] : p_r[off_c +: WORD_W];
        if (state_q == SUB)
            sum_c = {1'b0, opa_c} - {1'b0, opb_c} - (WORD_W+1)'(cy);
        else
            sum_c = {1'b0, opa_c} + {1'b0, opb_c} + (WORD_W+1)'(cy);
        last_c = (idx == IDX_W'(7));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath strobes; clr overrides everything
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        fin_c   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SUB;
                load_c  = 1'b1;
            end
            SUB: begin
                step_c = 1'b1;
                if (last_c) state_d = sum_c[WORD_W] ? FIX : DONE;
            end
            FIX: begin
                step_c = 1'b1;
                if (last_c) state_d = DONE;
            end
            DONE: begin
                fin_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            load_c  = 1'b0;
            step_c  = 1'b0;
            fin_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap_r    <= '0;
            an_r    <= '0;
            p_r     <= '0;
            work    <= '0;
            idx     <= '0;
            cy      <= 1'b0;
            neg     <= 1'b0;
            res     <= '0;
            flg_neg <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= fin_c;
            if (load_c) begin
                ap_r <= ap;
                an_r <= an;
                p_r  <= mod_p;
                work <= '0;
                idx  <= '0;
                cy   <= 1'b0;
            end else if (step_c) begin
                work[off_c +: WORD_W] <= sum_c[WORD_W-1:0];
                idx                   <= idx + IDX_W'(1);
                // Final SUB borrow is kept as the sign; FIX starts with carry clear
                if (state_q == SUB && last_c) begin
                    neg <= sum_c[WORD_W];
                    cy  <= 1'b0;
                end else begin
                    cy  <= sum_c[WORD_W];
                end
            end
            if (fin_c) begin
                res     <= work;
                flg_neg <= neg;
            end
        end
    end

endmodule

// File: tb/tb_mod_arith_rsd2bin.sv
// Directed-vector bench for mod_arith_rsd2bin with hand-computed results.
module tb_mod_arith_rsd2bin;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         clr;
    logic [255:0] ap, an, mod_p;
    logic [255:0] res;
    logic         flg_neg, busy, done;

    int checks   = 0;
    int failures = 0;

    mod_arith_rsd2bin dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clr     (clr),
        .ap      (ap),
        .an      (an),
        .mod_p   (mod_p),
        .res     (res),
        .flg_neg (flg_neg),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One conversion; inputs are scrambled right after acceptance.
    // lat = edges after the start edge until done is seen; bcnt = cycles busy was high.
    task automatic conv(input logic [255:0] a, input logic [255:0] n, input logic [255:0] p,
                        output int lat, output int bcnt);
        @(negedge clk);
        ap = a; an = n; mod_p = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ap = ~a; an = a; mod_p = ~p;
        lat = -1; bcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [255:0] p25519, exp_v;
    int lat, bcnt, ndone;

    initial begin
        p25519 = (256'd1 << 255) - 256'd19;
        rst = 1'b1; start = 1'b0; clr = 1'b0;
        ap = '0; an = '0; mod_p = '0;
        #12;
        check("rst_res", res, '0);
        check("rst_neg", 256'(flg_neg), '0);
        check("rst_busy", 256'(busy), '0);
        check("rst_done", 256'(done), '0);
        @(negedge clk); rst = 1'b0;

        conv(256'd5, 256'd3, 256'd7, lat, bcnt);
        check("t1_res", res, 256'd2);
        check("t1_neg", 256'(flg_neg), 256'd0);
        check("t1_lat", 256'(lat), 256'd9);
        check("t1_busy", 256'(bcnt), 256'd9);
        @(posedge clk); #1;
        check("t1_done_pulse", 256'(done), 256'd0);

        conv(256'd3, 256'd5, 256'd7, lat, bcnt);
        check("t2_res", res, 256'd5);
        check("t2_neg", 256'(flg_neg), 256'd1);
        check("t2_lat", 256'(lat), 256'd17);
        check("t2_busy", 256'(bcnt), 256'd17);

        conv(256'd1 << 32, 256'd1, p25519, lat, bcnt);
        check("t3_res", res, 256'hFFFF_FFFF);
        check("t3_neg", 256'(flg_neg), 256'd0);

        conv(256'd1, 256'd1 << 224, p25519, lat, bcnt);
        exp_v = p25519 - (256'd1 << 224) + 256'd1;
        check("t4_res", res, exp_v);
        check("t4_neg", 256'(flg_neg), 256'd1);

        conv(256'h1234_5678_9abc, 256'h1234_5678_9abc, 256'd7, lat, bcnt);
        check("eq_res", res, '0);
        check("eq_neg", 256'(flg_neg), 256'd0);
        check("eq_lat", 256'(lat), 256'd9);

        // out of range with p = 0: plain 256-bit wrap, still flagged as negative
        conv(256'd0, 256'd1, 256'd0, lat, bcnt);
        check("oor_res", res, {256{1'b1}});
        check("oor_neg", 256'(flg_neg), 256'd1);

        // start held high: exactly one done, inputs changed mid-run have no effect
        @(negedge clk);
        ap = 256'd3; an = 256'd5; mod_p = 256'd7; start = 1'b1;
        @(posedge clk); #1;
        ap = 256'd100; an = 256'd1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) check("hold_res_mid", res, {256{1'b1}});
            if (done) begin
                ndone++;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check("hold_ndone", 256'(ndone), 256'd1);
        check("hold_res", res, 256'd5);
        @(posedge clk); #1;
        check("hold_idle", 256'(busy), 256'd0);

        // async reset in the 4th FIX cycle
        @(negedge clk);
        ap = 256'd3; an = 256'd5; mod_p = 256'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 256'(busy), 256'd0);
        check("rst_mid_res", res, '0);
        ndone = 0;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("rst_mid_nodone", 256'(ndone), 256'd0);
        conv(256'd5, 256'd3, 256'd7, lat, bcnt);
        check("post_rst_res", res, 256'd2);
        check("post_rst_lat", 256'(lat), 256'd9);

        // clr in the 5th SUB cycle
        @(negedge clk);
        ap = 256'd3; an = 256'd5; mod_p = 256'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        check("clr_busy", 256'(busy), 256'd0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("clr_nodone", 256'(ndone), 256'd0);
        check("clr_res", res, 256'd2);
        conv(256'd3, 256'd5, 256'd7, lat, bcnt);
        check("post_clr_res", res, 256'd5);
        check("post_clr_lat", 256'(lat), 256'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
